// File: rtl/drop_board.sv
// drop_board: Connect-4 board stage. Takes a drop column from the cursor stage,
// finds the lowest free row, optionally animates the falling piece, then commits
// it to a 6x7 board and hands the turn to the other player.
// Optional feature macro: DROP_ANIM_EN (falling animation, FALL_TICKS cycles/row).
// Without it, an accepted drop goes straight to LAND.
module drop_board #(
  parameter int FALL_TICKS = 4
) (
  input  logic            CLOCK,
  input  logic            RST,
  input  logic            drop_valid,
  input  logic [3:0]      column,
  output logic            turn,
  output logic [5:0][6:0] RedBoard,
  output logic [5:0][6:0] GrnBoard,
  output logic            busy,
  output logic            drop_done,
  output logic            reject,
  output logic            board_full
);

  if (FALL_TICKS < 1) begin : g_bad_ticks
    $error("drop_board: FALL_TICKS must be >= 1");
  end

`ifdef DROP_ANIM_EN
  typedef enum logic [1:0] {IDLE = 2'd0, FALL = 2'd1, LAND = 2'd2} state_t;
  localparam int TW = (FALL_TICKS > 1) ? $clog2(FALL_TICKS) : 1;
  logic [TW-1:0] tick_q;
  logic          tick_last;
  assign tick_last = (tick_q == TW'(FALL_TICKS - 1));
`else
  typedef enum logic [1:0] {IDLE = 2'd0, LAND = 2'd2} state_t;
`endif

  state_t          st_q, st_d;
  logic [5:0][6:0] red_q, grn_q, ovl;
  logic [6:0][2:0] h_q;
  logic [2:0]      col_q, tgt_q, row_q, c_in, h_sel;
  logic            mover_q, turn_q, rej_q;
  logic            code_ok, full, accept;

  // Decode the request: column index, its stack height, and whether the drop is legal.
  always_comb begin
    code_ok = (column >= 4'd8) && (column <= 4'd14);
    c_in    = column[2:0];
    h_sel   = '0;
    full    = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (c_in == 3'(i)) h_sel = h_q[i];
      if (h_q[i] != 3'd6) full = 1'b0;
    end
    accept = (st_q == IDLE) && drop_valid && code_ok && (h_sel != 3'd6) && !full;
  end

  // State register.
  always_ff @(posedge CLOCK or negedge RST) begin
    if (!RST) st_q <= IDLE;
    else      st_q <= st_d;
  end

  // Next-state logic.
  always_comb begin
    st_d = st_q;
    case (st_q)
`ifdef DROP_ANIM_EN
      IDLE: if (accept) st_d = FALL;
      FALL: if (tick_last && (row_q == tgt_q)) st_d = LAND;
`else
      IDLE: if (accept) st_d = LAND;
`endif
      LAND: st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  // Datapath: latch the accepted drop, step the falling row, commit on LAND exit.
  always_ff @(posedge CLOCK or negedge RST) begin
    if (!RST) begin
      red_q   <= '0;
      grn_q   <= '0;
      h_q     <= '0;
      col_q   <= '0;
      tgt_q   <= '0;
      row_q   <= '0;
      mover_q <= 1'b0;
      turn_q  <= 1'b0;
      rej_q   <= 1'b0;
`ifdef DROP_ANIM_EN
      tick_q  <= '0;
`endif
    end else begin
      // Refusals are only reported from IDLE; requests while busy are dropped silently.
      rej_q <= (st_q == IDLE) && drop_valid && !accept;
      case (st_q)
        IDLE: begin
          if (accept) begin
            col_q   <= c_in;
            tgt_q   <= h_sel;
            mover_q <= turn_q;
`ifdef DROP_ANIM_EN
            row_q   <= 3'd5;
            tick_q  <= '0;
`else
            row_q   <= h_sel;
`endif
          end
        end
`ifdef DROP_ANIM_EN
        FALL: begin
          if (tick_last) begin
            tick_q <= '0;
            if (row_q != tgt_q) row_q <= row_q - 3'd1;
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
`endif
        LAND: begin
          for (int r = 0; r < 6; r++)
            for (int c = 0; c < 7; c++)
              if ((tgt_q == 3'(r)) && (col_q == 3'(c))) begin
                if (mover_q) grn_q[r][c] <= 1'b1;
                else         red_q[r][c] <= 1'b1;
              end
          for (int i = 0; i < 7; i++)
            if (col_q == 3'(i)) h_q[i] <= h_q[i] + 3'd1;
          turn_q <= ~turn_q;
        end
        default: ;
      endcase
    end
  end

  // Outputs from state: status flags and the falling-piece overlay cell.
  always_comb begin
    busy      = (st_q != IDLE);
    drop_done = (st_q == LAND);
    ovl       = '0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++)
        if (busy && (row_q == 3'(r)) && (col_q == 3'(c))) ovl[r][c] = 1'b1;
  end

  // Overlay sits above the stack, so it never collides with a committed cell.
  assign RedBoard   = red_q | (ovl & {42{~mover_q}});
  assign GrnBoard   = grn_q | (ovl & {42{mover_q}});
  assign turn       = turn_q;
  assign reject     = rej_q;
  assign board_full = full;

endmodule

// File: tb/tb_drop_board.sv
// Scoreboard bench for drop_board: the driver predicts each drop's outcome from
// the game rules and queues it; a negedge monitor checks every cycle's outputs.
module tb_drop_board;
  localparam int FT = 2;
`ifdef DROP_ANIM_EN
  localparam bit ANIM = 1'b1;
`else
  localparam bit ANIM = 1'b0;
`endif

  logic            CLOCK = 1'b0, RST = 1'b0, drop_valid = 1'b0;
  logic [3:0]      column = '0;
  logic            turn, busy, drop_done, reject, board_full;
  logic [5:0][6:0] RedBoard, GrnBoard;

  drop_board #(.FALL_TICKS(FT)) dut (
    .CLOCK(CLOCK), .RST(RST), .drop_valid(drop_valid), .column(column),
    .turn(turn), .RedBoard(RedBoard), .GrnBoard(GrnBoard), .busy(busy),
    .drop_done(drop_done), .reject(reject), .board_full(board_full)
  );

  always #5 CLOCK = ~CLOCK;

  int cyc = 0;
  always @(posedge CLOCK) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;

  typedef struct {
    bit              rej;
    int              col, tgt, issue;
    bit              color, nturn, nfull;
    logic [5:0][6:0] nred, ngrn;
  } exp_t;
  exp_t q[$];

  // Driver-side prediction state
  int              ph[7];
  logic [5:0][6:0] pr, pg;
  bit              pt;
  int              pcnt;
  // Monitor-side view of what the DUT should currently display
  logic [5:0][6:0] cr, cg;
  bit              ct, cfull;

  function automatic int lat(input int t);
    return ANIM ? (6 - t) * FT + 1 : 1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, req);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 7; i++) ph[i] = 0;
    pr = '0; pg = '0; pt = 0; pcnt = 0;
    cr = '0; cg = '0; ct = 0; cfull = 0;
    q.delete();
  endtask

  // Monitor: compare every output each cycle against the queued expectation.
  exp_t            me;
  logic [5:0][6:0] er, eg;
  bit              ebusy, edone, erej, pop;
  int              d, row;
  always @(negedge CLOCK) begin
    if (RST) begin
      er = cr; eg = cg; ebusy = 0; edone = 0; erej = 0; pop = 0;
      if (q.size() > 0) begin
        me = q[0];
        if (me.rej) begin
          if (cyc == me.issue + 1) begin erej = 1; pop = 1; end
        end else if (cyc >= me.issue + 1 && cyc <= me.issue + lat(me.tgt)) begin
          ebusy = 1;
          d = cyc - me.issue - 1;
          row = (ANIM && d < (6 - me.tgt) * FT) ? 5 - d / FT : me.tgt;
          if (me.color) eg[row][me.col] = 1'b1;
          else          er[row][me.col] = 1'b1;
          if (cyc == me.issue + lat(me.tgt)) begin edone = 1; pop = 1; end
        end
      end
      chk("busy", busy, ebusy);
      chk("drop_done", drop_done, edone);
      chk("reject", reject, erej);
      chk("RedBoard", RedBoard, er);
      chk("GrnBoard", GrnBoard, eg);
      chk("turn", turn, ct);
      chk("board_full", board_full, cfull);
      if (pop) begin
        void'(q.pop_front());
        if (!me.rej) begin cr = me.nred; cg = me.ngrn; ct = me.nturn; cfull = me.nfull; end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (q.size() > 0 && n < 300) begin @(posedge CLOCK); n++; end
    chk("drain_timeout", q.size(), 0);
    q.delete();
  endtask

  // Issue one drop request; the expected result comes from the game rules.
  task automatic drop(input logic [3:0] code, input bit mid_pulse, input bit nowait);
    exp_t e;
    int   c;
    @(posedge CLOCK); #1;
    e = '{default: 0};
    e.issue = cyc;
    c = int'(code) - 8;
    if (code >= 4'd8 && code <= 4'd14 && ph[c] < 6 && pcnt < 42) begin
      e.rej = 0; e.col = c; e.tgt = ph[c]; e.color = pt;
      if (pt) pg[ph[c]][c] = 1'b1; else pr[ph[c]][c] = 1'b1;
      ph[c]++; pt = ~pt; pcnt++;
      e.nred = pr; e.ngrn = pg; e.nturn = pt; e.nfull = (pcnt == 42);
    end else begin
      e.rej = 1;
    end
    q.push_back(e);
    drop_valid = 1'b1;
    column = code;
    @(posedge CLOCK); #1;
    if (mid_pulse && !e.rej) begin
      column = 4'($urandom_range(15, 0));
      @(posedge CLOCK); #1;
    end
    drop_valid = 1'b0;
    if (!nowait) wait_idle();
  endtask

  // Reset lands in the middle of an in-flight drop and must clear everything at once.
  task automatic reset_mid(input logic [3:0] code);
    drop(code, 0, 1);
    #1 RST = 1'b0;
    #1;
    chk("rst_red", RedBoard, 42'd0);
    chk("rst_grn", GrnBoard, 42'd0);
    chk("rst_turn", turn, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", drop_done, 0);
    chk("rst_full", board_full, 0);
    clear_model();
    @(posedge CLOCK); #1 RST = 1'b1;
  endtask

  initial begin
    clear_model();
    #1;
    chk("init_red", RedBoard, 42'd0);
    chk("init_grn", GrnBoard, 42'd0);
    chk("init_turn", turn, 0);
    chk("init_busy", busy, 0);
    chk("init_reject", reject, 0);
    chk("init_full", board_full, 0);
    repeat (2) @(posedge CLOCK);
    #1 RST = 1'b1;

    drop(4'd11, 0, 0);
    drop(4'd11, 0, 0);
    repeat (7) drop(4'd14, 0, 0);
    drop(4'd15, 0, 0);
    drop(4'd7, 0, 0);
    drop(4'd0, 0, 0);
    drop(4'd9, 1, 0);
    reset_mid(4'd10);
    drop(4'd12, 0, 0);
    drop(4'd12, 1, 0);
    reset_mid(4'd8);

    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(9, 0) < 8) drop(4'(8 + $urandom_range(6, 0)), $urandom_range(3, 0) == 0, 0);
      else                          drop(4'($urandom_range(15, 0)), 0, 0);
    end
    for (int c = 0; c < 7; c++)
      while (ph[c] < 6) drop(4'(c + 8), $urandom_range(3, 0) == 0, 0);
    repeat (3) @(posedge CLOCK);
    drop(4'd8, 0, 0);
    drop(4'd14, 0, 0);
    drop(4'($urandom_range(15, 0)), 0, 0);
    repeat (3) @(posedge CLOCK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cycle %0d: got running expected finished", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
